// File: rtl/axi_sram_responder_pkg.sv
// Shared AXI constants and helpers for the SRAM responder.
// Burst/response encodings, the throttle LFSR seed, and the address-advance rule
// used by both the read and write engines.
package axi_sram_responder_pkg;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10,
      AXI_BURST_RSVD  = 2'b11
   } axi_burst_t;

   typedef enum logic [1:0] {
      AXI_RESP_OKAY   = 2'b00,
      AXI_RESP_EXOKAY = 2'b01,
      AXI_RESP_SLVERR = 2'b10,
      AXI_RESP_DECERR = 2'b11
   } axi_resp_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Only FIXED and INCR with beats of at most one 32-bit word are served.
   function automatic logic burst_supported(input logic [1:0] burst, input logic [2:0] size);
      return ((burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR)) && (size <= 3'd2);
   endfunction

   // FIXED keeps the address; INCR steps by the beat size with plain 32-bit wrap.
   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                             input logic [2:0] size);
      if (burst == AXI_BURST_INCR)
         return addr + (32'd1 << size);
      return addr;
   endfunction

endpackage

// File: rtl/axi_sram_responder_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to throttle the responder's
// handshakes. Bit 0 of the output is the "stall this cycle" flag.
module axi_sram_lfsr
   import axi_sram_responder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_en,
   output logic [15:0] o_q
);

   logic [15:0] r_lfsr;
   logic        w_feedback;

   assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   // Shift register: seeded on reset, advances every enabled cycle.
   always_ff @(posedge clk) begin
      if (reset)
         r_lfsr <= LFSR_SEED;
      else if (i_en)
         r_lfsr <= {r_lfsr[14:0], w_feedback};
   end

   assign o_q = r_lfsr;

endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 responder backed by a word-addressed on-chip RAM.
// Independent read and write engines, one transaction in flight on each side,
// FIXED/INCR bursts, byte strobes, ID echo; unsupported bursts answer SLVERR.
// Optional build macro AXI_SRAM_THROTTLE_EN: an LFSR randomly stalls
// arready/awready/wready and delays raising rvalid for the next read beat.
module axi_sram_responder
   import axi_sram_responder_pkg::*;
#(
   parameter int MEM_AW = 12,
   parameter int ID_W   = 4
)(
   input  logic            clk,
   input  logic            reset,
   // read address
   input  logic [ID_W-1:0] arid,
   input  logic [31:0]     araddr,
   input  logic [7:0]      arlen,
   input  logic [2:0]      arsize,
   input  logic [1:0]      arburst,
   input  logic            arvalid,
   output logic            arready,
   // read data
   output logic [ID_W-1:0] rid,
   output logic [31:0]     rdata,
   output logic [1:0]      rresp,
   output logic            rlast,
   output logic            rvalid,
   input  logic            rready,
   // write address
   input  logic [ID_W-1:0] awid,
   input  logic [31:0]     awaddr,
   input  logic [7:0]      awlen,
   input  logic [2:0]      awsize,
   input  logic [1:0]      awburst,
   input  logic            awvalid,
   output logic            awready,
   // write data
   input  logic [ID_W-1:0] wid,
   input  logic [31:0]     wdata,
   input  logic [3:0]      wstrb,
   input  logic            wlast,
   input  logic            wvalid,
   output logic            wready,
   // write response
   output logic [ID_W-1:0] bid,
   output logic [1:0]      bresp,
   output logic            bvalid,
   input  logic            bready
);

   localparam int MEM_DEPTH = 1 << MEM_AW;

   typedef enum logic {R_IDLE, R_BEAT} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

   logic [31:0] r_mem [MEM_DEPTH];

   // ------------------------------------------------------------------
   // Throttle source
   // ------------------------------------------------------------------
   logic w_throttle;
   logic w_unused;

`ifdef AXI_SRAM_THROTTLE_EN
   logic [15:0] w_lfsr_q;

   axi_sram_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .i_en  (1'b1),
      .o_q   (w_lfsr_q)
   );

   assign w_throttle = w_lfsr_q[0];
   assign w_unused   = ^{wid, w_lfsr_q[15:1]};
`else
   assign w_throttle = 1'b0;
   assign w_unused   = ^wid;
`endif

   // ------------------------------------------------------------------
   // Read engine
   // ------------------------------------------------------------------
   rd_state_t         r_rd_state;
   rd_state_t         w_rd_state_next;
   logic [ID_W-1:0]   r_rid;
   logic [31:0]       r_rd_addr;
   logic [7:0]        r_rd_len;
   logic [2:0]        r_rd_size;
   logic [1:0]        r_rd_burst;
   logic [7:0]        r_rd_beat;
   logic              r_rd_err;
   logic              r_rvalid;
   logic [31:0]       r_rdata;

   logic              w_arready;
   logic              w_ar_hs;
   logic              w_r_hs;
   logic              w_rd_last_beat;
   logic [31:0]       w_rd_addr_next;
   logic              w_rd_load;
   logic              w_rd_zero;
   logic [MEM_AW-1:0] w_rd_idx;

   assign w_ar_hs        = arvalid & w_arready;
   assign w_r_hs         = r_rvalid & rready;
   assign w_rd_last_beat = (r_rd_beat == r_rd_len);
   assign w_rd_addr_next = next_addr(r_rd_addr, r_rd_burst, r_rd_size);

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (reset)
         r_rd_state <= R_IDLE;
      else
         r_rd_state <= w_rd_state_next;
   end

   // Read FSM next state: leave R_BEAT only when the final beat is taken.
   always_comb begin
      w_rd_state_next = r_rd_state;
      case (r_rd_state)
         R_IDLE:  if (w_ar_hs) w_rd_state_next = R_BEAT;
         R_BEAT:  if (w_r_hs && w_rd_last_beat) w_rd_state_next = R_IDLE;
         default: w_rd_state_next = R_IDLE;
      endcase
   end

   // Read FSM outputs: address channel open only while idle and not stalled.
   always_comb begin
      w_arready = (r_rd_state == R_IDLE) && !w_throttle;
   end

   // Read transaction context, beat counter and rvalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rvalid   <= 1'b0;
         r_rid      <= '0;
         r_rd_err   <= 1'b0;
         r_rd_addr  <= '0;
         r_rd_len   <= '0;
         r_rd_size  <= '0;
         r_rd_burst <= '0;
         r_rd_beat  <= '0;
      end else if (w_ar_hs) begin
         r_rid      <= arid;
         r_rd_addr  <= araddr;
         r_rd_len   <= arlen;
         r_rd_size  <= arsize;
         r_rd_burst <= arburst;
         r_rd_beat  <= '0;
         r_rd_err   <= !burst_supported(arburst, arsize);
         r_rvalid   <= 1'b1;
      end else if (r_rd_state == R_BEAT) begin
         if (w_r_hs) begin
            if (w_rd_last_beat) begin
               r_rvalid <= 1'b0;
            end else begin
               r_rd_beat <= r_rd_beat + 8'd1;
               r_rd_addr <= w_rd_addr_next;
               // A stalled cycle drops rvalid between beats; never within one.
               r_rvalid  <= !w_throttle;
            end
         end else if (!r_rvalid && !w_throttle) begin
            r_rvalid <= 1'b1;
         end
      end
   end

   // Pick which word the registered RAM read fetches this cycle, and when.
   always_comb begin
      w_rd_load = w_ar_hs
                | (w_r_hs && !w_rd_last_beat && !w_throttle)
                | ((r_rd_state == R_BEAT) && !r_rvalid && !w_throttle);
      if (w_ar_hs)
         w_rd_idx = araddr[MEM_AW+1:2];
      else if (w_r_hs)
         w_rd_idx = w_rd_addr_next[MEM_AW+1:2];
      else
         w_rd_idx = r_rd_addr[MEM_AW+1:2];
      w_rd_zero = w_ar_hs ? !burst_supported(arburst, arsize) : r_rd_err;
   end

   // Registered RAM read; samples the pre-write value on a same-cycle write.
   always_ff @(posedge clk) begin
      if (reset)
         r_rdata <= '0;
      else if (w_rd_load)
         r_rdata <= w_rd_zero ? 32'd0 : r_mem[w_rd_idx];
   end

   assign arready = w_arready;
   assign rvalid  = r_rvalid;
   assign rlast   = r_rvalid && w_rd_last_beat;
   assign rdata   = r_rdata;
   assign rid     = r_rid;
   assign rresp   = r_rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

   // ------------------------------------------------------------------
   // Write engine
   // ------------------------------------------------------------------
   wr_state_t         r_wr_state;
   wr_state_t         w_wr_state_next;
   logic [ID_W-1:0]   r_bid;
   logic [1:0]        r_bresp;
   logic [31:0]       r_wr_addr;
   logic [7:0]        r_wr_len;
   logic [2:0]        r_wr_size;
   logic [1:0]        r_wr_burst;
   logic [8:0]        r_wr_beat;
   logic              r_wr_err;

   logic              w_awready;
   logic              w_wready;
   logic              w_bvalid;
   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_mem_we;
   logic [3:0]        w_byte_we;
   logic [MEM_AW-1:0] w_wr_idx;

   assign w_aw_hs  = awvalid & w_awready;
   assign w_w_hs   = wvalid & w_wready;
   assign w_wr_idx = r_wr_addr[MEM_AW+1:2];
   // Beats past the announced length are swallowed without touching the RAM.
   assign w_mem_we = w_w_hs && !r_wr_err && (r_wr_beat <= {1'b0, r_wr_len});

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
         assign w_byte_we[gi] = w_mem_we & wstrb[gi];
      end
   endgenerate

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (reset)
         r_wr_state <= W_IDLE;
      else
         r_wr_state <= w_wr_state_next;
   end

   // Write FSM next state: wlast ends the data phase regardless of awlen.
   always_comb begin
      w_wr_state_next = r_wr_state;
      case (r_wr_state)
         W_IDLE:  if (w_aw_hs) w_wr_state_next = W_DATA;
         W_DATA:  if (w_w_hs && wlast) w_wr_state_next = W_RESP;
         W_RESP:  if (bready) w_wr_state_next = W_IDLE;
         default: w_wr_state_next = W_IDLE;
      endcase
   end

   // Write FSM outputs: channel readiness follows state, stalled by the throttle.
   always_comb begin
      w_awready = (r_wr_state == W_IDLE) && !w_throttle;
      w_wready  = (r_wr_state == W_DATA) && !w_throttle;
      w_bvalid  = (r_wr_state == W_RESP);
   end

   // Write transaction context, beat counter and response code.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bid      <= '0;
         r_bresp    <= AXI_RESP_OKAY;
         r_wr_addr  <= '0;
         r_wr_len   <= '0;
         r_wr_size  <= '0;
         r_wr_burst <= '0;
         r_wr_beat  <= '0;
         r_wr_err   <= 1'b0;
      end else if (w_aw_hs) begin
         r_bid      <= awid;
         r_wr_addr  <= awaddr;
         r_wr_len   <= awlen;
         r_wr_size  <= awsize;
         r_wr_burst <= awburst;
         r_wr_beat  <= '0;
         r_wr_err   <= !burst_supported(awburst, awsize);
      end else if (w_w_hs) begin
         r_wr_addr <= next_addr(r_wr_addr, r_wr_burst, r_wr_size);
         // Saturate so a runaway master cannot wrap back into the valid range.
         if (r_wr_beat != 9'h1FF)
            r_wr_beat <= r_wr_beat + 9'd1;
         if (wlast)
            r_bresp <= (r_wr_err || (r_wr_beat != {1'b0, r_wr_len})) ? AXI_RESP_SLVERR
                                                                      : AXI_RESP_OKAY;
      end
   end

   // RAM write port with per-byte enables.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (w_byte_we[b])
            r_mem[w_wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign awready = w_awready;
   assign wready  = w_wready;
   assign bvalid  = w_bvalid;
   assign bid     = r_bid;
   assign bresp   = r_bresp;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Self-checking bench for axi_sram_responder: a table of directed write/read
// transactions with hand-computed data, plus sequences for rready back-pressure
// and reset in the middle of a read burst.
module tb_axi_sram_responder;

   logic        clk;
   logic        reset;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int total = 0;
   int bad   = 0;

   axi_sram_responder #(.MEM_AW(12), .ID_W(4)) dut (
      .clk(clk), .reset(reset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  id;
      logic [3:0]  strb;
      int          nbeats;   // W beats actually sent (wlast on the final one)
      logic [31:0] dbase;    // beat b data = dbase + b*dstep (written or expected)
      logic [31:0] dstep;
      logic [1:0]  resp;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   function automatic vec_t mk(bit wr, logic [31:0] addr, logic [7:0] len, logic [2:0] size,
                               logic [1:0] burst, logic [3:0] id, logic [3:0] strb, int nbeats,
                               logic [31:0] dbase, logic [31:0] dstep, logic [1:0] resp);
      vec_t v;
      v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
      v.strb = strb; v.nbeats = nbeats; v.dbase = dbase; v.dstep = dstep; v.resp = resp;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic do_write(input vec_t v, input int idx);
      int n;
      awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
      awvalid = 1'b1;
      n = 0;
      while (awready !== 1'b1 && n < 50) begin tick(); n++; end
      chk($sformatf("v%0d awready", idx), 32'(awready), 32'd1);
      tick();
      awvalid = 1'b0;
      for (int b = 0; b < v.nbeats; b++) begin
         wid    = v.id;
         wdata  = v.dbase + 32'(b) * v.dstep;
         wstrb  = v.strb;
         wlast  = (b == v.nbeats - 1);
         wvalid = 1'b1;
         n = 0;
         while (wready !== 1'b1 && n < 50) begin tick(); n++; end
         chk($sformatf("v%0d wready b%0d", idx, b), 32'(wready), 32'd1);
         tick();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      chk($sformatf("v%0d bvalid", idx), 32'(bvalid), 32'd1);
      chk($sformatf("v%0d bresp", idx), 32'(bresp), 32'(v.resp));
      chk($sformatf("v%0d bid", idx), 32'(bid), 32'(v.id));
      $display("txn %0d WR addr=%08h len=%0d beats=%0d bresp=%0d bid=%0h",
               idx, v.addr, v.len, v.nbeats, bresp, bid);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk($sformatf("v%0d bvalid drop", idx), 32'(bvalid), 32'd0);
      chk($sformatf("v%0d awready back", idx), 32'(awready), 32'd1);
   endtask

   task automatic do_read(input vec_t v, input int idx);
      int n;
      arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
      arvalid = 1'b1;
      n = 0;
      while (arready !== 1'b1 && n < 50) begin tick(); n++; end
      chk($sformatf("v%0d arready", idx), 32'(arready), 32'd1);
      tick();
      arvalid = 1'b0;
      rready  = 1'b1;
      // One-cycle latency and back-to-back beats: no waiting allowed here.
      for (int b = 0; b <= int'(v.len); b++) begin
         chk($sformatf("v%0d rvalid b%0d", idx, b), 32'(rvalid), 32'd1);
         chk($sformatf("v%0d rdata b%0d", idx, b), rdata, v.dbase + 32'(b) * v.dstep);
         chk($sformatf("v%0d rlast b%0d", idx, b), 32'(rlast), 32'(b == int'(v.len)));
         chk($sformatf("v%0d rid b%0d", idx, b), 32'(rid), 32'(v.id));
         chk($sformatf("v%0d rresp b%0d", idx, b), 32'(rresp), 32'(v.resp));
         tick();
      end
      rready = 1'b0;
      chk($sformatf("v%0d rvalid drop", idx), 32'(rvalid), 32'd0);
      chk($sformatf("v%0d arready back", idx), 32'(arready), 32'd1);
      $display("txn %0d RD addr=%08h len=%0d burst=%0d rresp=%0d", idx, v.addr, v.len,
               v.burst, v.resp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;

      //            wr    addr            len  sz    burst  id     strb   nb  dbase          dstep  resp
      vecs[0]  = mk(1'b1, 32'h0000_0040, 8'd3, 3'd2, 2'b01, 4'h1, 4'hF,   4, 32'h0000_0000, 32'd1, 2'b00);
      vecs[1]  = mk(1'b0, 32'h0000_0040, 8'd3, 3'd2, 2'b01, 4'h2, 4'h0,   0, 32'h0000_0000, 32'd1, 2'b00);
      vecs[2]  = mk(1'b1, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 4'h3, 4'hF,   4, 32'h0000_00A0, 32'd1, 2'b00);
      vecs[3]  = mk(1'b0, 32'h0000_0100, 8'd3, 3'd2, 2'b01, 4'h4, 4'h0,   0, 32'h0000_00A0, 32'd1, 2'b00);
      vecs[4]  = mk(1'b1, 32'h0000_0200, 8'd0, 3'd2, 2'b01, 4'h5, 4'hF,   1, 32'h1122_3344, 32'd0, 2'b00);
      vecs[5]  = mk(1'b1, 32'h0000_0200, 8'd0, 3'd2, 2'b01, 4'h6, 4'b0010,1, 32'h0000_AB00, 32'd0, 2'b00);
      vecs[6]  = mk(1'b0, 32'h0000_0200, 8'd0, 3'd2, 2'b01, 4'h7, 4'h0,   0, 32'h1122_AB44, 32'd0, 2'b00);
      vecs[7]  = mk(1'b0, 32'h0000_0100, 8'd2, 3'd2, 2'b00, 4'h8, 4'h0,   0, 32'h0000_00A0, 32'd0, 2'b00);
      vecs[8]  = mk(1'b0, 32'h0000_0044, 8'd3, 3'd0, 2'b01, 4'h9, 4'h0,   0, 32'h0000_0001, 32'd0, 2'b00);
      vecs[9]  = mk(1'b0, 32'h0000_4044, 8'd0, 3'd2, 2'b01, 4'hA, 4'h0,   0, 32'h0000_0001, 32'd0, 2'b00);
      vecs[10] = mk(1'b1, 32'h0000_0500, 8'd3, 3'd2, 2'b01, 4'hB, 4'hF,   2, 32'h0000_0050, 32'd1, 2'b10);
      vecs[11] = mk(1'b0, 32'h0000_0500, 8'd1, 3'd2, 2'b01, 4'hC, 4'h0,   0, 32'h0000_0050, 32'd1, 2'b00);
      vecs[12] = mk(1'b0, 32'h0000_0040, 8'd1, 3'd2, 2'b11, 4'hD, 4'h0,   0, 32'h0000_0000, 32'd0, 2'b10);
      vecs[13] = mk(1'b0, 32'h0000_0040, 8'd0, 3'd3, 2'b01, 4'hE, 4'h0,   0, 32'h0000_0000, 32'd0, 2'b10);
      vecs[14] = mk(1'b1, 32'h0000_0040, 8'd0, 3'd2, 2'b10, 4'hF, 4'hF,   1, 32'h0000_00FF, 32'd0, 2'b10);
      vecs[15] = mk(1'b0, 32'h0000_0040, 8'd1, 3'd2, 2'b01, 4'h0, 4'h0,   0, 32'h0000_0000, 32'd1, 2'b00);
      vecs[16] = mk(1'b1, 32'h0000_0300, 8'd2, 3'd2, 2'b00, 4'h1, 4'hF,   3, 32'h0000_0010, 32'd1, 2'b00);
      vecs[17] = mk(1'b0, 32'h0000_0300, 8'd0, 3'd2, 2'b01, 4'h2, 4'h0,   0, 32'h0000_0012, 32'd0, 2'b00);
      vecs[18] = mk(1'b1, 32'h0000_0600, 8'd0, 3'd2, 2'b01, 4'h3, 4'hF,   3, 32'h0000_0070, 32'd1, 2'b10);
      vecs[19] = mk(1'b0, 32'h0000_0600, 8'd0, 3'd2, 2'b01, 4'h4, 4'h0,   0, 32'h0000_0070, 32'd0, 2'b00);

      reset = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      rready = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      tick();
      tick();

      chk("rst arready", 32'(arready), 32'd1);
      chk("rst awready", 32'(awready), 32'd1);
      chk("rst rvalid",  32'(rvalid),  32'd0);
      chk("rst rlast",   32'(rlast),   32'd0);
      chk("rst rdata",   rdata,        32'd0);
      chk("rst rresp",   32'(rresp),   32'd0);
      chk("rst rid",     32'(rid),     32'd0);
      chk("rst wready",  32'(wready),  32'd0);
      chk("rst bvalid",  32'(bvalid),  32'd0);
      chk("rst bresp",   32'(bresp),   32'd0);
      chk("rst bid",     32'(bid),     32'd0);
      $display("txn reset state checked");

      reset = 1'b0;
      tick();

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].wr)
            do_write(vecs[i], i);
         else
            do_read(vecs[i], i);
      end

      // rready held low for 5 cycles in the middle of a burst.
      arid = 4'h9; araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
      arvalid = 1'b1;
      chk("bp arready", 32'(arready), 32'd1);
      tick();
      arvalid = 1'b0;
      rready  = 1'b1;
      chk("bp rdata b0", rdata, 32'hA0);
      tick();
      rready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp hold%0d rvalid", k), 32'(rvalid), 32'd1);
         chk($sformatf("bp hold%0d rdata", k), rdata, 32'hA1);
         chk($sformatf("bp hold%0d rlast", k), 32'(rlast), 32'd0);
         tick();
      end
      rready = 1'b1;
      for (int b = 1; b <= 3; b++) begin
         chk($sformatf("bp rvalid b%0d", b), 32'(rvalid), 32'd1);
         chk($sformatf("bp rdata b%0d", b), rdata, 32'hA0 + 32'(b));
         chk($sformatf("bp rlast b%0d", b), 32'(rlast), 32'(b == 3));
         tick();
      end
      rready = 1'b0;
      chk("bp rvalid drop", 32'(rvalid), 32'd0);
      $display("txn backpressure read addr=00000100 len=3 done");

      // Reset in the middle of a read burst abandons it.
      arid = 4'h5; araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      rready  = 1'b1;
      chk("mr rdata b0", rdata, 32'hA0);
      tick();
      rready = 1'b0;
      chk("mr rvalid before reset", 32'(rvalid), 32'd1);
      reset = 1'b1;
      tick();
      chk("mr rvalid", 32'(rvalid), 32'd0);
      chk("mr arready", 32'(arready), 32'd1);
      chk("mr rid", 32'(rid), 32'd0);
      reset = 1'b0;
      $display("txn reset mid-burst done");
      v = mk(1'b0, 32'h0000_0104, 8'd0, 3'd2, 2'b01, 4'h6, 4'h0, 0, 32'h0000_00A1, 32'd0, 2'b00);
      do_read(v, 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
